servo_slew_seq: RTL and testbench

SERVO_SLEW_SEQ -- requirements
Module: servo_slew_seq

---
 rtl/servo_slew_seq.sv | 160 ++++++++++++++++
 tb/tb_servo_slew_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_slew_seq.sv
// Pan/tilt servo sequencer: parks both axes at centre, holds them there
// for a number of arming frames, then slews toward commanded targets by a
// bounded amount once per servo frame.
module servo_slew_seq #(
    parameter int FRAME_TICKS = 2000000,
    parameter int MAX_STEP    = 16,
    parameter int ARM_FRAMES  = 25,
    parameter int CENTER      = 2048
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        cmd_valid,
    input  logic [11:0] cmd_x,
    input  logic [11:0] cmd_y,
    output logic        cmd_ready,
    output logic [11:0] angle_x,
    output logic [11:0] angle_y,
    output logic        servo_en,
    output logic        frame_tick,
    output logic        settled,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int CNT_W = (FRAME_TICKS > 2) ? $clog2(FRAME_TICKS) : 1;
    localparam int ARM_W = $clog2(ARM_FRAMES + 1);

    localparam logic [CNT_W-1:0]  LAST_TICK    = CNT_W'(FRAME_TICKS - 1);
    localparam logic [ARM_W-1:0]  LAST_ARM     = ARM_W'(ARM_FRAMES - 1);
    localparam logic [11:0]       CENTER_ANGLE = 12'(CENTER);
    localparam logic [11:0]       STEP_U       = 12'(MAX_STEP);
    localparam logic signed [12:0] STEP_POS    = 13'(MAX_STEP);
    localparam logic signed [12:0] STEP_NEG    = -13'(MAX_STEP);

    state_t            state_q,     state_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [ARM_W-1:0]  arm_cnt_q,   arm_cnt_d;
    logic [11:0]       tgt_x_q,     tgt_x_d;
    logic [11:0]       tgt_y_q,     tgt_y_d;
    logic [11:0]       angle_x_q,   angle_x_d;
    logic [11:0]       angle_y_q,   angle_y_d;
    logic              servo_en_q,  servo_en_d;
    logic              transfer;

    // One bounded step toward the target; the 13-bit signed difference keeps
    // the full 0..4095 span representable, and a step is only taken when it
    // cannot reach or pass the target, so the result never overshoots or wraps.
    function automatic logic [11:0] slew_toward(input logic [11:0] angle,
                                                input logic [11:0] target);
        logic signed [12:0] diff;
        diff = signed'({1'b0, target}) - signed'({1'b0, angle});
        if (diff > STEP_POS) begin
            slew_toward = angle + STEP_U;
        end else if (diff < STEP_NEG) begin
            slew_toward = angle - STEP_U;
        end else begin
            slew_toward = target;
        end
    endfunction

    assign cmd_ready  = (state_q != IDLE);
    assign transfer   = cmd_valid && cmd_ready;
    assign frame_tick = (state_q != IDLE) && (frame_cnt_q == LAST_TICK);
    assign settled    = (state_q == RUN) && (angle_x_q == tgt_x_q) && (angle_y_q == tgt_y_q);
    assign servo_en   = servo_en_q;
    assign angle_x    = angle_x_q;
    assign angle_y    = angle_y_q;
    assign state      = state_q;

    // Next-state logic: disarm has priority, then frame counting, target capture,
    // arming progress and the once-per-frame slew using the previously stored target.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        arm_cnt_d   = arm_cnt_q;
        tgt_x_d     = tgt_x_q;
        tgt_y_d     = tgt_y_q;
        angle_x_d   = angle_x_q;
        angle_y_d   = angle_y_q;

        case (state_q)
            IDLE: begin
                frame_cnt_d = '0;
                arm_cnt_d   = '0;
                tgt_x_d     = CENTER_ANGLE;
                tgt_y_d     = CENTER_ANGLE;
                angle_x_d   = CENTER_ANGLE;
                angle_y_d   = CENTER_ANGLE;
                if (enable) begin
                    state_d = ARM;
                end
            end
            ARM, RUN: begin
                if (!enable) begin
                    state_d     = IDLE;
                    frame_cnt_d = '0;
                    arm_cnt_d   = '0;
                    tgt_x_d     = CENTER_ANGLE;
                    tgt_y_d     = CENTER_ANGLE;
                    angle_x_d   = CENTER_ANGLE;
                    angle_y_d   = CENTER_ANGLE;
                end else begin
                    frame_cnt_d = frame_tick ? '0 : frame_cnt_q + 1'b1;
                    if (transfer) begin
                        tgt_x_d = cmd_x;
                        tgt_y_d = cmd_y;
                    end
                    if (frame_tick) begin
                        if (state_q == ARM) begin
                            if (arm_cnt_q == LAST_ARM) begin
                                state_d   = RUN;
                                arm_cnt_d = '0;
                            end else begin
                                arm_cnt_d = arm_cnt_q + 1'b1;
                            end
                        end else begin
                            angle_x_d = slew_toward(angle_x_q, tgt_x_q);
                            angle_y_d = slew_toward(angle_y_q, tgt_y_q);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        servo_en_d = (state_d != IDLE);
    end

    // State and datapath registers; reset parks the servos immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            arm_cnt_q   <= '0;
            tgt_x_q     <= CENTER_ANGLE;
            tgt_y_q     <= CENTER_ANGLE;
            angle_x_q   <= CENTER_ANGLE;
            angle_y_q   <= CENTER_ANGLE;
            servo_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            arm_cnt_q   <= arm_cnt_d;
            tgt_x_q     <= tgt_x_d;
            tgt_y_q     <= tgt_y_d;
            angle_x_q   <= angle_x_d;
            angle_y_q   <= angle_y_d;
            servo_en_q  <= servo_en_d;
        end
    end

endmodule

// File: tb/tb_servo_slew_seq.sv
// Bench for servo_slew_seq: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a frame-level model.
module tb_servo_slew_seq;

    localparam int FT = 10;
    localparam int MS = 16;
    localparam int AF = 2;
    localparam int C  = 2048;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        cmd_valid;
    logic [11:0] cmd_x;
    logic [11:0] cmd_y;
    logic        cmd_ready;
    logic [11:0] angle_x;
    logic [11:0] angle_y;
    logic        servo_en;
    logic        frame_tick;
    logic        settled;
    logic [1:0]  state;

    servo_slew_seq #(
        .FRAME_TICKS(FT),
        .MAX_STEP   (MS),
        .ARM_FRAMES (AF),
        .CENTER     (C)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .cmd_valid (cmd_valid),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_ready (cmd_ready),
        .angle_x   (angle_x),
        .angle_y   (angle_y),
        .servo_en  (servo_en),
        .frame_tick(frame_tick),
        .settled   (settled),
        .state     (state)
    );

    // 100 MHz-style clock, period 10
    always #5 clock = ~clock;

    typedef struct {
        int en;
        int valid;
        int cx;
        int cy;
        int n;
        int st;
        int ax;
        int ay;
        int setl;
        int tick;
    } vec_t;

    vec_t vecs [10];

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: mode (0 parked, 1 arming, 2 running), position inside
    // the frame, completed arming frames, stored targets and angles.
    int m_mode, m_phase, m_armf, m_tgt_x, m_tgt_y, m_ax, m_ay;

    function automatic int approach(input int a, input int t);
        int d;
        d = t - a;
        if (d > MS)  return a + MS;
        if (d < -MS) return a - MS;
        return t;
    endfunction

    function automatic void modelReset();
        m_mode  = 0;
        m_phase = 0;
        m_armf  = 0;
        m_tgt_x = C;
        m_tgt_y = C;
        m_ax    = C;
        m_ay    = C;
    endfunction

    function automatic void modelAdvance();
        bit tick;
        bit take;
        if (reset) begin
            modelReset();
            return;
        end
        tick = (m_mode != 0) && (m_phase == FT - 1);
        take = cmd_valid && (m_mode != 0);
        if (m_mode == 0) begin
            if (enable) begin
                m_mode  = 1;
                m_phase = 0;
                m_armf  = 0;
            end
        end else if (!enable) begin
            modelReset();
        end else begin
            if (tick && m_mode == 2) begin
                m_ax = approach(m_ax, m_tgt_x);
                m_ay = approach(m_ay, m_tgt_y);
            end
            if (take) begin
                m_tgt_x = int'(cmd_x);
                m_tgt_y = int'(cmd_y);
            end
            if (tick && m_mode == 1) begin
                m_armf++;
                if (m_armf == AF) m_mode = 2;
            end
            m_phase = (m_phase + 1) % FT;
        end
    endfunction

    task automatic checkVal(input string name, input int got, input int want);
        n_compared++;
        if (got != want) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, want %0d", name, $time, got, want);
        end
    endtask

    task automatic checkOutput();
        checkVal("model.state",      int'(state),      m_mode);
        checkVal("model.servo_en",   int'(servo_en),   int'(m_mode != 0));
        checkVal("model.cmd_ready",  int'(cmd_ready),  int'(m_mode != 0));
        checkVal("model.frame_tick", int'(frame_tick), int'(m_mode != 0 && m_phase == FT - 1));
        checkVal("model.angle_x",    int'(angle_x),    m_ax);
        checkVal("model.angle_y",    int'(angle_y),    m_ay);
        checkVal("model.settled",    int'(settled),
                 int'(m_mode == 2 && m_ax == m_tgt_x && m_ay == m_tgt_y));
    endtask

    task automatic checkExpect(input string tag, input int st, input int ax, input int ay,
                               input int setl, input int tick);
        checkVal({tag, ".state"},      int'(state),      st);
        checkVal({tag, ".servo_en"},   int'(servo_en),   int'(st != 0));
        checkVal({tag, ".cmd_ready"},  int'(cmd_ready),  int'(st != 0));
        checkVal({tag, ".angle_x"},    int'(angle_x),    ax);
        checkVal({tag, ".angle_y"},    int'(angle_y),    ay);
        checkVal({tag, ".settled"},    int'(settled),    setl);
        checkVal({tag, ".frame_tick"}, int'(frame_tick), tick);
    endtask

    task automatic applyStimulus(input int en, input int valid, input int x, input int y);
        enable    = (en != 0);
        cmd_valid = (valid != 0);
        cmd_x     = 12'(x);
        cmd_y     = 12'(y);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            modelAdvance();
            @(negedge clock);
            checkOutput();
        end
    endtask

    task automatic rearm();
        applyStimulus(0, 0, 0, 0);
        step(1);
        applyStimulus(1, 0, 0, 0);
        step(21);
        checkExpect("rearm", 2, C, C, 1, 0);
    endtask

    function automatic int randAngle();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return 4095;
            default: return int'($urandom_range(0, 4095));
        endcase
    endfunction

    initial begin
        int r;

        // en valid cx cy n | state ax ay settled tick (n edges after applying inputs)
        vecs[0] = '{1, 0, 0,    0,    1,  1, C,    C,    0, 0};
        vecs[1] = '{1, 0, 0,    0,    9,  1, C,    C,    0, 1};
        vecs[2] = '{1, 0, 0,    0,    1,  1, C,    C,    0, 0};
        vecs[3] = '{1, 0, 0,    0,    9,  1, C,    C,    0, 1};
        vecs[4] = '{1, 0, 0,    0,    1,  2, C,    C,    1, 0};
        vecs[5] = '{1, 1, 2100, 2000, 1,  2, C,    C,    0, 0};
        vecs[6] = '{1, 0, 0,    0,    9,  2, 2064, 2032, 0, 0};
        vecs[7] = '{1, 0, 0,    0,    10, 2, 2080, 2016, 0, 0};
        vecs[8] = '{1, 0, 0,    0,    10, 2, 2096, 2000, 0, 0};
        vecs[9] = '{1, 0, 0,    0,    10, 2, 2100, 2000, 1, 0};

        reset = 1'b1;
        applyStimulus(0, 0, 0, 0);
        modelReset();
        repeat (2) @(negedge clock);
        checkExpect("reset", 0, C, C, 0, 0);
        reset = 1'b0;
        step(1);
        checkExpect("idle_hold", 0, C, C, 0, 0);

        // arming and the basic slew
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].en, vecs[i].valid, vecs[i].cx, vecs[i].cy);
            step(1);
            cmd_valid = 1'b0;
            if (vecs[i].n > 1) step(vecs[i].n - 1);
            checkExpect($sformatf("vec%0d", i), vecs[i].st, vecs[i].ax, vecs[i].ay,
                        vecs[i].setl, vecs[i].tick);
        end

        // disarm in the middle of a slew, then re-arm
        applyStimulus(1, 1, 3000, 3000);
        step(1);
        cmd_valid = 1'b0;
        step(9);
        checkExpect("slew_3000", 2, 2116, 2016, 0, 0);
        applyStimulus(0, 0, 0, 0);
        step(1);
        checkExpect("disarm", 0, C, C, 0, 0);
        applyStimulus(1, 0, 0, 0);
        step(1);
        checkExpect("arm_again", 1, C, C, 0, 0);
        step(8);
        checkExpect("pre_tick", 1, C, C, 0, 0);
        step(1);
        checkExpect("first_tick", 1, C, C, 0, 1);
        step(11);
        checkExpect("run_again", 2, C, C, 1, 0);

        // transfer landing on a frame_tick cycle
        step(9);
        checkExpect("tick_before_collide", 2, C, C, 1, 1);
        applyStimulus(1, 1, 3000, 3000);
        step(1);
        cmd_valid = 1'b0;
        checkExpect("collide", 2, C, C, 0, 0);
        step(10);
        checkExpect("after_collide", 2, 2064, 2064, 0, 0);

        // small step and range extremes from centre
        rearm();
        applyStimulus(1, 1, 2050, 4095);
        step(1);
        cmd_valid = 1'b0;
        step(9);
        checkExpect("small_step", 2, 2050, 2064, 0, 0);
        step(1300);
        checkExpect("y_max", 2, 2050, 4095, 1, 0);
        applyStimulus(1, 1, 0, 0);
        step(1);
        cmd_valid = 1'b0;
        step(2609);
        checkExpect("zero", 2, 0, 0, 1, 0);

        // asynchronous reset between clock edges mid-slew
        applyStimulus(1, 1, 1000, 3500);
        step(1);
        cmd_valid = 1'b0;
        step(25);
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkExpect("async_reset", 0, C, C, 0, 0);
        step(1);
        reset = 1'b0;
        step(1);
        checkExpect("post_reset_arm", 1, C, C, 0, 0);
        step(20);
        checkExpect("post_reset_run", 2, C, C, 1, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 999));
            reset = (r < 3);
            if (reset) modelReset();
            applyStimulus((r >= 3 && r < 8) ? 0 : 1, int'($urandom_range(0, 5) == 0),
                          randAngle(), randAngle());
            step(1);
        end
        reset = 1'b0;
        cmd_valid = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
